// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic lamp sequencer.
//   lamp_t      - physical lamp code driven to each approach
//   seq_state_t - per-approach sequencer state
//   DEF_*       - default interval lengths and counter width
//   lamp_decode - maps a sequencer state onto the lamp it shows
package traffic_pkg;

    typedef enum logic [1:0] {
        LAMP_RED    = 2'b00,
        LAMP_GREEN  = 2'b01,
        LAMP_YELLOW = 2'b10
    } lamp_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_ALLRED
    } seq_state_t;

    localparam int DEF_MIN_GREEN  = 4;
    localparam int DEF_YELLOW_CYC = 3;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_CNT_W      = 8;

    // IDLE and ALLRED both show red; only GREEN and YELLOW light up.
    function automatic lamp_t lamp_decode(input seq_state_t s);
        case (s)
            S_GREEN:  return LAMP_GREEN;
            S_YELLOW: return LAMP_YELLOW;
            default:  return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_lamp_sequencer_if.sv
// Grant/lamp bundle between the traffic controller and the lamp sequencer.
//   n_go, s_go, e_go        - level grants from the controller
//   n_lamp, s_lamp, e_lamp  - lamp codes per approach
//   ns_idle, e_idle         - sequencer idle indications
//   conflict                - sticky overlapping-grant flag
// master: controller side (drives grants); slave: sequencer side.
interface traffic_lamp_sequencer_if;
    import traffic_pkg::*;

    logic  n_go;
    logic  s_go;
    logic  e_go;
    lamp_t n_lamp;
    lamp_t s_lamp;
    lamp_t e_lamp;
    logic  ns_idle;
    logic  e_idle;
    logic  conflict;

    modport master (
        output n_go, s_go, e_go,
        input  n_lamp, s_lamp, e_lamp, ns_idle, e_idle, conflict
    );

    modport slave (
        input  n_go, s_go, e_go,
        output n_lamp, s_lamp, e_lamp, ns_idle, e_idle, conflict
    );

endinterface

// File: rtl/traffic_lamp_fsm.sv
// Single-approach lamp sequencer: IDLE -> GREEN -> YELLOW -> ALLRED -> IDLE.
//   clk, rst     - clock, asynchronous active-high reset
//   go           - level grant for this approach
//   cross_clear  - opposing direction is idle, so GREEN may be entered
//   lamp         - registered lamp code
//   idle         - sequencer is in IDLE
module traffic_lamp_fsm
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  go,
    input  logic  cross_clear,
    output lamp_t lamp,
    output logic  idle
);

    // Counters hold "cycles remaining minus one" so the exit test is cnt==0.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lamp_t            lamp_q, lamp_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lamp_q  <= LAMP_RED;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lamp_q  <= lamp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        // Saturating decrement: the counter parks at 0 rather than wrapping.
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (go && cross_clear) begin
                    state_d = S_GREEN;
                    cnt_d   = GREEN_LD;
                end
            end
            S_GREEN: begin
                // A held grant extends GREEN; an early drop waits out MIN_GREEN.
                if (cnt_q == '0 && !go) begin
                    state_d = S_YELLOW;
                    cnt_d   = YELLOW_LD;
                end
            end
            S_YELLOW: begin
                if (cnt_q == '0) begin
                    state_d = S_ALLRED;
                    cnt_d   = ALLRED_LD;
                end
            end
            S_ALLRED: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Lamp is decoded from the next state so it lines up with state_q.
        lamp_d = lamp_decode(state_d);
    end

    assign lamp = lamp_q;
    assign idle = (state_q == S_IDLE);

endmodule

// File: rtl/traffic_lamp_sequencer.sv
// Traffic lamp sequencer top: three per-approach FSMs plus the N/S vs E
// interlock, N/S priority on simultaneous starts and a sticky conflict flag.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - slave side of the grant/lamp bundle
module traffic_lamp_sequencer
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN  = DEF_MIN_GREEN,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    traffic_lamp_sequencer_if.slave  bus
);

    logic n_idle;
    logic s_idle;
    logic e_idle_w;
    logic ns_clear;
    logic e_clear;
    logic conflict_q, conflict_d;

    // N/S only need E to be idle. E additionally yields to any N/S grant,
    // so a simultaneous start from all-idle goes to N/S.
    assign ns_clear = e_idle_w;
    assign e_clear  = n_idle & s_idle & ~(bus.n_go | bus.s_go);

    traffic_lamp_fsm #(
        .MIN_GREEN(MIN_GREEN), .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC), .CNT_W(CNT_W)
    ) u_n (
        .clk(clk), .rst(rst), .go(bus.n_go), .cross_clear(ns_clear),
        .lamp(bus.n_lamp), .idle(n_idle)
    );

    traffic_lamp_fsm #(
        .MIN_GREEN(MIN_GREEN), .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC), .CNT_W(CNT_W)
    ) u_s (
        .clk(clk), .rst(rst), .go(bus.s_go), .cross_clear(ns_clear),
        .lamp(bus.s_lamp), .idle(s_idle)
    );

    traffic_lamp_fsm #(
        .MIN_GREEN(MIN_GREEN), .YELLOW_CYC(YELLOW_CYC),
        .ALLRED_CYC(ALLRED_CYC), .CNT_W(CNT_W)
    ) u_e (
        .clk(clk), .rst(rst), .go(bus.e_go), .cross_clear(e_clear),
        .lamp(bus.e_lamp), .idle(e_idle_w)
    );

    assign conflict_d = conflict_q | (bus.e_go & (bus.n_go | bus.s_go));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign bus.ns_idle  = n_idle & s_idle;
    assign bus.e_idle   = e_idle_w;
    assign bus.conflict = conflict_q;

    // E must never be lit while either N or S is lit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!((bus.e_lamp != LAMP_RED) &&
                      ((bus.n_lamp != LAMP_RED) || (bus.s_lamp != LAMP_RED))));
        end
    end

endmodule

// File: tb/tb_traffic_lamp_sequencer.sv
// Scoreboard bench for traffic_lamp_sequencer (MIN_GREEN=4, YELLOW_CYC=3,
// ALLRED_CYC=2). Stimulus queues hand-computed expectations tagged with the
// clock-edge count at which they hold; a monitor pops and compares them.
module tb_traffic_lamp_sequencer;
    import traffic_pkg::*;

    localparam int SEL_N  = 0;
    localparam int SEL_S  = 1;
    localparam int SEL_E  = 2;
    localparam int SEL_NSI = 3;
    localparam int SEL_EI = 4;
    localparam int SEL_CF = 5;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_cnt = 0;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   base;
    exp_t sb[$];

    traffic_lamp_sequencer_if bus();

    traffic_lamp_sequencer #(
        .MIN_GREEN(4), .YELLOW_CYC(3), .ALLRED_CYC(2), .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int sample(input int sel);
        case (sel)
            SEL_N:   return int'(bus.n_lamp);
            SEL_S:   return int'(bus.s_lamp);
            SEL_E:   return int'(bus.e_lamp);
            SEL_NSI: return int'(bus.ns_idle);
            SEL_EI:  return int'(bus.e_idle);
            SEL_CF:  return int'(bus.conflict);
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Sorted insert so the monitor can always work from the queue head.
    task automatic expect_at(input int cyc, input int sel, input int val, input string name);
        exp_t it;
        int   i;
        it.cyc = cyc; it.sel = sel; it.val = val; it.name = name;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > cyc) i--;
        sb.insert(i, it);
    endtask

    task automatic expect_rng(input int b, input int from, input int to,
                              input int sel, input int val, input string name);
        for (int k = from; k <= to; k++) expect_at(b + k, sel, val, name);
    endtask

    // Monitor: sample just after each rising edge.
    always @(posedge clk) begin
        exp_t it;
        int   inv_ok;
        #1;
        inv_ok = ((bus.e_lamp != LAMP_RED) &&
                  ((bus.n_lamp != LAMP_RED) || (bus.s_lamp != LAMP_RED))) ? 0 : 1;
        check("interlock", inv_ok, 1);
        while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
            it = sb.pop_front();
            if (it.cyc < edge_cnt) begin
                chk_cnt++;
                $display("FAIL %s: expectation for edge %0d missed, now %0d", it.name, it.cyc, edge_cnt);
            end else begin
                check(it.name, sample(it.sel), it.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.n_go = 1'b0;
        bus.s_go = 1'b0;
        bus.e_go = 1'b0;

        // 1: reset held for two edges
        @(negedge clk);
        base = edge_cnt;
        expect_at(base + 1, SEL_N, 0, "t1_rst_n_lamp");
        expect_at(base + 1, SEL_S, 0, "t1_rst_s_lamp");
        expect_at(base + 1, SEL_E, 0, "t1_rst_e_lamp");
        expect_at(base + 1, SEL_NSI, 1, "t1_rst_ns_idle");
        expect_at(base + 1, SEL_EI, 1, "t1_rst_e_idle");
        expect_at(base + 1, SEL_CF, 0, "t1_rst_conflict");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 2: one-cycle N grant still gets full MIN_GREEN
        base = edge_cnt;
        bus.n_go = 1'b1;
        expect_rng(base, 1, 4, SEL_N, 1, "t2_n_green");
        expect_rng(base, 5, 7, SEL_N, 2, "t2_n_yellow");
        expect_rng(base, 8, 9, SEL_N, 0, "t2_n_allred");
        expect_at(base + 9, SEL_NSI, 0, "t2_ns_busy");
        expect_at(base + 10, SEL_NSI, 1, "t2_ns_idle");
        @(negedge clk);
        bus.n_go = 1'b0;
        repeat (11) @(negedge clk);

        // 3: N held, E requested as N drops; E waits through ALLRED
        base = edge_cnt;
        bus.n_go = 1'b1;
        expect_rng(base, 1, 10, SEL_N, 1, "t3_n_green");
        expect_rng(base, 11, 13, SEL_N, 2, "t3_n_yellow");
        expect_rng(base, 14, 15, SEL_N, 0, "t3_n_allred");
        expect_at(base + 15, SEL_NSI, 0, "t3_ns_busy");
        expect_at(base + 16, SEL_NSI, 1, "t3_ns_idle");
        expect_rng(base, 1, 16, SEL_E, 0, "t3_e_hold");
        expect_at(base + 17, SEL_E, 1, "t3_e_green");
        expect_at(base + 21, SEL_E, 2, "t3_e_yellow");
        expect_at(base + 20, SEL_CF, 0, "t3_no_conflict");
        expect_at(base + 25, SEL_EI, 0, "t3_e_busy");
        expect_at(base + 26, SEL_EI, 1, "t3_e_idle");
        repeat (10) @(negedge clk);
        bus.n_go = 1'b0;
        bus.e_go = 1'b1;
        repeat (7) @(negedge clk);
        bus.e_go = 1'b0;
        repeat (12) @(negedge clk);

        // 4: N and S together, E requested while they are green
        base = edge_cnt;
        bus.n_go = 1'b1;
        bus.s_go = 1'b1;
        expect_rng(base, 1, 6, SEL_N, 1, "t4_n_green");
        expect_at(base + 3, SEL_S, 1, "t4_s_green");
        expect_rng(base, 7, 9, SEL_N, 2, "t4_n_yellow");
        expect_at(base + 7, SEL_S, 2, "t4_s_yellow");
        expect_at(base + 10, SEL_N, 0, "t4_n_allred");
        expect_rng(base, 1, 12, SEL_E, 0, "t4_e_hold");
        expect_at(base + 12, SEL_NSI, 1, "t4_ns_idle");
        expect_at(base + 13, SEL_E, 1, "t4_e_green");
        expect_at(base + 2, SEL_CF, 0, "t4_conflict_pre");
        expect_at(base + 3, SEL_CF, 1, "t4_conflict_set");
        expect_at(base + 22, SEL_EI, 1, "t4_e_idle");
        @(negedge clk);
        @(negedge clk);
        bus.e_go = 1'b1;
        repeat (4) @(negedge clk);
        bus.n_go = 1'b0;
        bus.s_go = 1'b0;
        repeat (7) @(negedge clk);
        bus.e_go = 1'b0;
        repeat (12) @(negedge clk);

        // 6: asynchronous reset in the middle of N YELLOW
        base = edge_cnt;
        bus.n_go = 1'b1;
        expect_rng(base, 1, 4, SEL_N, 1, "t6_n_green");
        expect_at(base + 5, SEL_N, 2, "t6_n_yellow");
        @(negedge clk);
        bus.n_go = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_pre_rst_yellow", sample(SEL_N), 2);
        rst = 1'b1;
        #1;
        check("t6_async_n_lamp", sample(SEL_N), 0);
        check("t6_async_ns_idle", sample(SEL_NSI), 1);
        check("t6_async_conflict", sample(SEL_CF), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = edge_cnt;
        bus.n_go = 1'b1;
        expect_rng(base, 1, 4, SEL_N, 1, "t6_re_green");
        expect_at(base + 5, SEL_N, 2, "t6_re_yellow");
        expect_at(base + 8, SEL_N, 0, "t6_re_allred");
        @(negedge clk);
        bus.n_go = 1'b0;
        repeat (12) @(negedge clk);

        // 5: E and N on the same edge from all-idle; E grant is not latched
        base = edge_cnt;
        bus.n_go = 1'b1;
        bus.e_go = 1'b1;
        expect_at(base + 1, SEL_N, 1, "t5_n_green");
        expect_rng(base, 1, 12, SEL_E, 0, "t5_e_blocked");
        expect_at(base + 1, SEL_CF, 1, "t5_conflict_set");
        expect_at(base + 10, SEL_NSI, 1, "t5_ns_idle");
        expect_at(base + 12, SEL_EI, 1, "t5_e_idle");
        expect_at(base + 21, SEL_CF, 1, "t5_conflict_sticky");
        @(negedge clk);
        bus.n_go = 1'b0;
        bus.e_go = 1'b0;
        repeat (22) @(negedge clk);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        while (sb.size() > 0) begin
            chk_cnt++;
            $display("FAIL %s: expectation for edge %0d never checked", sb[0].name, sb[0].cyc);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/traffic_lamp_sequencer.md
Name: traffic_lamp_sequencer

Overview:
- Downstream stage of the north/south/east traffic-light controller.
- Consumes the controller's level-valued grants (n_go, s_go, e_go) and drives the physical lamp codes for each approach.
- Enforces a minimum green time, a yellow interval and an all-red clearance interval.
- Adds a cross-direction interlock: E never shows green while any N/S lamp is non-idle, and vice versa, even if the grants overlap in time.

Parameters:
- MIN_GREEN, 4, minimum cycles a lamp stays GREEN; must be >=1
- YELLOW_CYC, 3, cycles in YELLOW; must be >=1
- ALLRED_CYC, 2, cycles in all-red clearance after YELLOW; must be >=1
- CNT_W, 8, interval counter width; every interval parameter must be < 2**CNT_W

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- n_go  in  1  north grant from controller (level)
- s_go  in  1  south grant from controller (level)
- e_go  in  1  east grant from controller (level)
- n_lamp  out  2  north lamp: 00 RED, 01 GREEN, 10 YELLOW (11 never driven)
- s_lamp  out  2  south lamp, same encoding
- e_lamp  out  2  east lamp, same encoding
- ns_idle  out  1  both N and S sequencers in IDLE
- e_idle  out  1  E sequencer in IDLE
- conflict  out  1  sticky flag: e_go sampled high in the same cycle as n_go or s_go

Behaviour:
- Reset (async, any time, including mid-interval):
  - all sequencers go to IDLE; counters go to 0; all lamps 00; conflict 0; ns_idle 1; e_idle 1.
  - Takes effect immediately, not at the next edge.
- Each approach has a 4-state registered FSM: IDLE, GREEN, YELLOW, ALLRED.
  - Lamp output is a registered decode: IDLE and ALLRED show 00, GREEN shows 01, YELLOW shows 10.
- IDLE -> GREEN when go=1 and cross_clear=1.
  - Counter loads MIN_GREEN-1.
  - Lamp shows 01 in the cycle after the edge that sampled go (latency 1).
- GREEN:
  - counter decrements to 0 and saturates there.
  - Leaves to YELLOW only when counter==0 and go==0; counter loads YELLOW_CYC-1.
  - If go is held, GREEN lasts indefinitely.
  - go dropping early does not shorten GREEN below MIN_GREEN cycles.
- YELLOW: decrement; at counter==0 -> ALLRED, counter loads ALLRED_CYC-1. go is ignored in this state.
- ALLRED: decrement; at counter==0 -> IDLE. go is ignored; a go still high re-enters GREEN no earlier than the cycle after IDLE is reached.
- cross_clear:
  - for N and S = E sequencer in IDLE.
  - for E = N and S sequencers both in IDLE.
  - Uses current state, not next state.
- N and S may be GREEN simultaneously; they never interlock each other.
- Simultaneous start from all-IDLE (e_go and n_go/s_go sampled high on the same edge):
  - N/S wins; E stays IDLE until ns_idle.
  - conflict is set to 1 on that edge and holds until reset.
- A grant that drops while its sequencer is still waiting in IDLE (blocked by the interlock) is dropped; it is not latched.
- Invariant: never (e_lamp!=00 and (n_lamp!=00 or s_lamp!=00)).
  - Checked with an immediate assertion.
  - A liveness property "go held -> eventually GREEN" holds under a fairness assumption that opposing grants eventually drop.
- Counter arithmetic is unsigned CNT_W bits; the counter never wraps because decrement saturates at 0.

Decomposition:
- Shared package traffic_pkg:
  - lamp_t enum (RED=2'b00, GREEN=2'b01, YELLOW=2'b10)
  - seq_state_t enum (IDLE, GREEN, YELLOW, ALLRED)
  - default interval constants
- One sub-module, traffic_lamp_fsm:
  - ports: clk, rst, go, cross_clear, lamp, idle.
  - parameterised by MIN_GREEN, YELLOW_CYC, ALLRED_CYC, CNT_W.
  - instantiated three times.
- The top holds only the interlock wiring, the N/S priority gating of E, and the conflict flag.

Test Plan (MIN_GREEN=4, YELLOW_CYC=3, ALLRED_CYC=2):
1. Assert rst for 2 cycles, all go=0 -> all lamps 00, ns_idle=1, e_idle=1, conflict=0.
2. n_go=1 sampled at edge 0, n_go=0 from edge 1 -> n_lamp 01 in cycles 1-4, 10 in cycles 5-7, 00 from cycle 8; ns_idle=1 from cycle 10.
3. n_go=1 for edges 0-9, e_go rises at edge 10 as n_go falls -> n_lamp yellow in cycles 11-13; e_lamp stays 00 through the all-red interval; e_lamp becomes 01 the cycle after ns_idle=1.
4. n_go=s_go=1 together, then e_go=1 -> N and S both GREEN; e_lamp held 00; invariant never violated.
5. e_go=n_go=1 on the same edge from idle -> n_lamp 01, e_lamp 00, conflict=1 and still 1 after 20 cycles.
6. rst asserted asynchronously during N YELLOW -> n_lamp 00 before the next clock edge; after release, a new n_go gives a full 4-cycle green.
